ps2_event_receiver: RTL and testbench
=====================================

# ps2_event_receiver

Parametrised PS/2 keyboard front end that replaces the fixed byte-to-LED path with a buffered key-event stream. It synchronises and deglitches PS2_CLK/PS2_DATA, deserialises and checks 11-bit frames, and folds E0/F0 prefixes into single make/break events. Events are queued in a FIFO with a valid/ready output. The block sits between the keyboard pins and the key-exchange/display logic, and keeps a `last_code` byte for the existing LED and seven-segment decoder.

## Interface
- FILTER_LEN, 8: consecutive identical samples required before the filtered PS2_CLK changes level (≥2).
- TIMEOUT_CYCLES, 100000: maximum CLK cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two, ≥2.
- CLK  input  1  board clock; all state is on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PS2_CLK  input  1  keyboard clock, asynchronous.
- PS2_DATA  input  1  keyboard data, asynchronous.
- evt_valid  output  1  FIFO not empty; head event is presented.
- evt_ready  input  1  consumer accepts the head event when evt_valid=1.
- evt_code  output  8  scan code of the head event.
- evt_ext  output  1  head event was E0-prefixed.
- evt_break  output  1  head event is a key release (F0-prefixed).
- evt_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- last_code  output  8  most recent non-prefix code pushed; drives the LED/segment decoder.
- frame_err  output  1  one-cycle pulse on a start, parity, stop or timeout error.
- overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Input path: a 2-flop synchroniser on each pin. PS2_CLK then passes through a FILTER_LEN saturating filter. A falling edge of the filtered clock samples the synchronised PS2_DATA.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on a sampled 0 (start bit). A sampled 1 is ignored and the FSM stays in IDLE.
  - DATA shifts 8 bits in LSB first, then goes to PARITY.
  - PARITY stores the bit. Odd parity over data+parity is required.
  - STOP requires a 1. On pass, the byte goes to the decoder. On fail, frame_err pulses. Either way the FSM returns to IDLE.
- Timeout: a counter runs in every state except IDLE and clears on each falling edge. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, frame_err pulses, and prefix flags clear.
- Decoder:
  - E0 sets ext_pend. F0 sets brk_pend. Neither pushes an event.
  - Any other byte pushes {ext_pend, brk_pend, byte}, then clears both flags.
  - A frame error clears both flags.
- FIFO:
  - Push when the decoder emits. Pop when evt_valid && evt_ready.
  - Full and push without pop: drop the new event and pulse overflow. FIFO contents are unchanged.
  - Full with simultaneous push and pop: both happen, no overflow, count unchanged.
  - Empty with push: the event becomes the head. Read pointers wrap modulo FIFO_DEPTH.
- last_code updates on every accepted push and on every dropped push.
- Reset values:
  - All outputs are 0.
  - FSM is IDLE. Filtered clock is 1. Pointers, counters and prefix flags are 0.
  - Reset mid-frame discards the partial byte and all queued events.

## Timing
- Falling edge on the PS2_CLK pin to the sample cycle: 2 sync cycles + FILTER_LEN filter cycles + 1 edge-detect cycle.
- The decoder acts in the cycle after the stop-bit sample. The push lands in the next cycle.
- evt_valid, evt_count and last_code are registered. They reflect a push one cycle after the push cycle.
- Head fields are show-ahead: they are valid whenever evt_valid=1 and stable until popped.
- A pop presents the next entry, or deasserts evt_valid, on the following cycle.
- frame_err and overflow are exactly one cycle wide. They never assert during reset.
- evt_ready is ignored while evt_valid=0.

## Configuration
- KBD_BREAK_EVENTS_EN defined: break events are pushed with evt_break=1, as described above.
- KBD_BREAK_EVENTS_EN undefined:
  - The byte following F0 is consumed: no push, no last_code update.
  - brk_pend still clears after that byte.
  - evt_break is tied to 0.
  - Only make events reach the FIFO.

## Test plan
- Valid frame for 0x1C (parity 0, stop 1), evt_ready=0 → after the stop bit, evt_valid=1, evt_code=0x1C, evt_ext=0, evt_break=0, evt_count=1, last_code=0x1C.
- Sequence E0, F0, 0x75 → exactly one event: code 0x75, ext=1, break=1 (none with the macro undefined). evt_count increments by 1 only.
- 0x1C frame with the parity bit flipped → frame_err pulses for one cycle, no push. A following clean 0x32 frame yields code 0x32 with ext=0, break=0.
- Clock stops after 4 data bits for TIMEOUT_CYCLES+10 → frame_err pulses once, FSM is back in IDLE, and the next clean frame decodes correctly.
- FIFO_DEPTH=4, evt_ready=0, six make codes 0x01..0x06 → evt_count=4, overflow pulses twice, last_code=0x06. Draining with evt_ready=1 yields 0x01..0x04 in order.
- RST_N pulled low mid-frame while the FIFO holds 2 events → all outputs 0 immediately (asynchronous). After release, a clean 0x29 frame yields a single event with code 0x29.

Source files
------------

// File: rtl/ps2_event_receiver.sv
// PS/2 keyboard receiver: pin sync/deglitch, 11-bit frame check, E0/F0 folding, event FIFO.
// Define KBD_BREAK_EVENTS_EN to queue key-release events; otherwise the byte after F0 is consumed.
module ps2_event_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic [7:0]                    last_code,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
`ifdef KBD_BREAK_EVENTS_EN
    localparam logic BRK_EN = 1'b1;
`else
    localparam logic BRK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers and clock filter idle high so reset never fabricates a falling edge.
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall, data_bit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_MAX) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall     = filt_prev_q & ~filt_q;
    assign data_bit = data_sync_q[1];

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    byte_q;
    logic          byte_vld_q, frame_err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == IDLE || fall) tmo_q <= '0;
            else                         tmo_q <= tmo_q + TW'(1);

            if (state_q != IDLE && !fall && tmo_q == TMO_MAX) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: if (!data_bit) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= data_bit;
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (data_bit && (^{shift_q, par_q})) begin
                            byte_q     <= shift_q;
                            byte_vld_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Prefix folding; push_data_q is {ext, break, code}.
    logic       ext_pend_q, brk_pend_q, push_q;
    logic [9:0] push_data_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (frame_err_q) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_vld_q) begin
                if (byte_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    push_q      <= BRK_EN | ~brk_pend_q;
                    push_data_q <= {ext_pend_q, brk_pend_q & BRK_EN, byte_q};
                    ext_pend_q  <= 1'b0;
                    brk_pend_q  <= 1'b0;
                end
            end
        end
    end

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    last_code_q;
    logic          overflow_q, pop, wr, full;
    logic [9:0]    head;

    always_comb begin
        pop     = (count_q != '0) && evt_ready;
        full    = (count_q == DEPTH);
        wr      = push_q && (!full || pop);
        count_d = count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            last_code_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wptr_q] <= push_data_q;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= push_q && !wr;
            if (push_q) last_code_q <= push_data_q[7:0];
        end
    end

    assign head      = mem_q[rptr_q];
    assign evt_valid = (count_q != '0);
    assign evt_code  = head[7:0];
    assign evt_ext   = head[9];
    assign evt_break = head[8] & BRK_EN;
    assign evt_count = count_q;
    assign last_code = last_code_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_event_receiver.sv
// Directed bench for ps2_event_receiver (FIFO_DEPTH=4, short timeout).
module tb_ps2_event_receiver;
    localparam int unsigned TMO = 400;
    localparam int unsigned H   = 30;

    logic       CLK = 1'b0, RST_N = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1, evt_ready = 1'b0;
    logic       evt_valid, evt_ext, evt_break, frame_err, overflow;
    logic [7:0] evt_code, last_code;
    logic [2:0] evt_count;

    int compared = 0, mismatched = 0;
    int ferr_cycles = 0, ovf_cycles = 0;
    int f0, o0;

    ps2_event_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .evt_count(evt_count),
        .last_code(last_code), .frame_err(frame_err), .overflow(overflow));

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (frame_err) ferr_cycles++;
        if (overflow)  ovf_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DATA = bits[i];
            repeat (H) @(negedge CLK);
            PS2_CLK = 1'b0;
            repeat (H) @(negedge CLK);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip);
        ps2_bits(frame(b, flip), 11);
        repeat (H) @(negedge CLK);
    endtask

    task automatic pop1;
        evt_ready = 1'b1;
        @(negedge CLK);
        evt_ready = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge CLK);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code",  32'(evt_code),  0);
        chk("rst_ext",   32'(evt_ext),   0);
        chk("rst_break", 32'(evt_break), 0);
        chk("rst_count", 32'(evt_count), 0);
        chk("rst_last",  32'(last_code), 0);
        chk("rst_ferr",  32'(frame_err), 0);
        chk("rst_ovf",   32'(overflow),  0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);

        send(8'h1C, 1'b0);
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_code",  32'(evt_code),  'h1C);
        chk("t1_ext",   32'(evt_ext),   0);
        chk("t1_break", 32'(evt_break), 0);
        chk("t1_count", 32'(evt_count), 1);
        chk("t1_last",  32'(last_code), 'h1C);
        pop1();
        chk("t1_popped", 32'(evt_count), 0);

        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
`ifdef KBD_BREAK_EVENTS_EN
        chk("t2_count", 32'(evt_count), 1);
        chk("t2_code",  32'(evt_code),  'h75);
        chk("t2_ext",   32'(evt_ext),   1);
        chk("t2_break", 32'(evt_break), 1);
        chk("t2_last",  32'(last_code), 'h75);
        pop1();
`else
        chk("t2_count", 32'(evt_count), 0);
        chk("t2_last",  32'(last_code), 'h1C);
`endif
        chk("t2_valid", 32'(evt_valid), 0);

        f0 = ferr_cycles;
        send(8'h1C, 1'b1);
        chk("t3_ferr_pulse", 32'(ferr_cycles - f0), 1);
        chk("t3_nopush",     32'(evt_count), 0);
        send(8'h32, 1'b0);
        chk("t3_code",  32'(evt_code),  'h32);
        chk("t3_ext",   32'(evt_ext),   0);
        chk("t3_break", 32'(evt_break), 0);
        chk("t3_count", 32'(evt_count), 1);
        pop1();

        f0 = ferr_cycles;
        ps2_bits(frame(8'h2A, 1'b0), 5);
        repeat (TMO + 10) @(negedge CLK);
        chk("t4_ferr_pulse", 32'(ferr_cycles - f0), 1);
        chk("t4_nopush",     32'(evt_count), 0);
        send(8'h2A, 1'b0);
        chk("t4_code",  32'(evt_code),  'h2A);
        chk("t4_count", 32'(evt_count), 1);
        chk("t4_noerr", 32'(ferr_cycles - f0), 1);
        pop1();

        o0 = ovf_cycles;
        f0 = ferr_cycles;
        for (int b = 1; b <= 6; b++) send(8'(b), 1'b0);
        chk("t5_count", 32'(evt_count), 4);
        chk("t5_ovf",   32'(ovf_cycles - o0), 2);
        chk("t5_last",  32'(last_code), 'h06);
        chk("t5_ferr",  32'(ferr_cycles - f0), 0);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t5_drain", 32'(evt_code), 32'(i));
            @(negedge CLK);
        end
        evt_ready = 1'b0;
        chk("t5_empty", 32'(evt_valid), 0);
        chk("t5_count0", 32'(evt_count), 0);

        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        chk("t6_count2", 32'(evt_count), 2);
        ps2_bits(frame(8'h55, 1'b0), 4);
        repeat (H / 2) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 0);
        chk("t6_rst_count", 32'(evt_count), 0);
        chk("t6_rst_last",  32'(last_code), 0);
        chk("t6_rst_code",  32'(evt_code),  0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        send(8'h29, 1'b0);
        chk("t6_count", 32'(evt_count), 1);
        chk("t6_code",  32'(evt_code),  'h29);
        chk("t6_ext",   32'(evt_ext),   0);
        chk("t6_last",  32'(last_code), 'h29);
        pop1();
        chk("t6_single", 32'(evt_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
